// File: rtl/apu_regs_pkg.sv
// APU register-window decoder: shared constants and register index names.
// Imported by the decoder and its phase-edge helper.
package apu_regs_pkg;

    localparam logic [15:0] APU_REG_BASE    = 16'h4000;
    localparam int          APU_ASEL_W      = 5;
    localparam int          APU_NUM_REGS    = 27;
    localparam int          APU_DEBUG_FIRST = 24;

    localparam int IDX_4000 = 0;
    localparam int IDX_4003 = 3;
    localparam int IDX_4015 = 21;
    localparam int IDX_4017 = 23;
    localparam int IDX_4018 = 24;
    localparam int IDX_401A = 26;

endpackage

// File: rtl/apu_regs_decoder_seq_edge.sv
// PHI1 rising-edge detector sampled on CLK.
// The history flop resets high so a phase already open at reset release is ignored.
module apu_phase_edge (
    input  logic clk,
    input  logic rst,
    input  logic phi1,
    output logic rise
);

    logic phi1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            phi1_q <= 1'b1;
        end else begin
            phi1_q <= phi1;
        end
    end

    assign rise = phi1 & ~phi1_q;

endmodule

// File: rtl/apu_regs_decoder_seq.sv
// Registered APU register-window decoder: one-shot write strobes,
// level read enables, debug-gated indices and a sticky unmapped-write flag.
module apu_regs_decoder_seq
    import apu_regs_pkg::*;
#(
    parameter logic [15:0] BASE        = APU_REG_BASE,
    parameter int          ASEL_W      = APU_ASEL_W,
    parameter int          NUM_REGS    = APU_NUM_REGS,
    parameter int          DEBUG_FIRST = APU_DEBUG_FIRST
) (
    input  logic                CLK,
    input  logic                RES,
    input  logic                PHI1,
    input  logic [15:0]         Addr_fromcore,
    input  logic [15:0]         Addr_frommux,
    input  logic                RnW_fromcore,
    input  logic                DBG_frompad,
    output logic [NUM_REGS-1:0] W,
    output logic [NUM_REGS-1:0] n_R,
    output logic                n_DBGRD,
    output logic [ASEL_W-1:0]   LastIdx,
    output logic                ErrUnmapped
);

    localparam int          NUM_P = NUM_REGS;
    localparam int          DBG_P = DEBUG_FIRST;
    localparam logic [ASEL_W:0] NUM_L = NUM_P[ASEL_W:0];
    localparam logic [ASEL_W:0] DBG_L = DBG_P[ASEL_W:0];

    logic              phi1_rise;
    logic [ASEL_W-1:0] idx;
    logic              hit;
    logic              is_dbg;
    logic              valid;
    logic              wr_edge;
    logic              rd_act;
    logic              unused_bits;

    logic [NUM_REGS-1:0] w_next;
    logic [NUM_REGS-1:0] r_next;
    logic                dbg_next;

    apu_phase_edge u_edge (
        .clk  (CLK),
        .rst  (RES),
        .phi1 (PHI1),
        .rise (phi1_rise)
    );

    // Core address only qualifies the window; the mux address picks the index.
    assign unused_bits = ^{Addr_fromcore[ASEL_W-1:0], Addr_frommux[15:ASEL_W]};

    assign hit     = (Addr_fromcore[15:ASEL_W] == BASE[15:ASEL_W]) & PHI1;
    assign idx     = Addr_frommux[ASEL_W-1:0];
    assign is_dbg  = {1'b0, idx} >= DBG_L;
    assign valid   = ({1'b0, idx} < NUM_L) & (~is_dbg | DBG_frompad);
    assign wr_edge = hit & ~RnW_fromcore & phi1_rise;
    assign rd_act  = hit & RnW_fromcore & valid;

    always_comb begin
        w_next   = '0;
        r_next   = '1;
        dbg_next = ~(rd_act & is_dbg & DBG_frompad);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == i[ASEL_W-1:0]) begin
                w_next[i] = wr_edge & valid;
                r_next[i] = ~rd_act;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            W           <= '0;
            n_R         <= '1;
            n_DBGRD     <= 1'b1;
            LastIdx     <= '0;
            ErrUnmapped <= 1'b0;
        end else begin
            W       <= w_next;
            n_R     <= r_next;
            n_DBGRD <= dbg_next;
            if (wr_edge & valid) begin
                LastIdx <= idx;
            end
            if (wr_edge & ~valid) begin
                ErrUnmapped <= 1'b1;
            end
        end
    end

endmodule
